// File: rtl/sdram_pkg.sv
// Shared types for the two-client SDRAM front end: bus width defaults,
// arbiter state encoding and client identifiers.
package sdram_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_IDLE      = 2'd1,
    S_ISSUE     = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_t;

  function automatic client_t other_client(input client_t c);
    return (c == CLIENT_A) ? CLIENT_B : CLIENT_A;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of client A/B request ports and the controller handshake.
// master = arbiter side, slave = clients plus controller side.
interface sdram_arbiter_if #(
  parameter int ADDR_W = sdram_pkg::DEF_ADDR_W,
  parameter int DATA_W = sdram_pkg::DEF_DATA_W
);

  logic              a_start;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] a_q;
  logic              a_done;

  logic              b_start;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_d;
  logic [DATA_W-1:0] b_q;
  logic              b_done;

  logic              ctl_start;
  logic              ctl_we;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_d;
  logic              ctl_busy;
  logic [DATA_W-1:0] ctl_q;
  logic              ctl_q_ready;
  logic              ctl_init_done;

  modport master (
    input  a_start, a_we, a_addr, a_d,
    output a_q, a_done,
    input  b_start, b_we, b_addr, b_d,
    output b_q, b_done,
    output ctl_start, ctl_we, ctl_addr, ctl_d,
    input  ctl_busy, ctl_q, ctl_q_ready, ctl_init_done
  );

  modport slave (
    output a_start, a_we, a_addr, a_d,
    input  a_q, a_done,
    output b_start, b_we, b_addr, b_d,
    input  b_q, b_done,
    input  ctl_start, ctl_we, ctl_addr, ctl_d,
    output ctl_busy, ctl_q, ctl_q_ready, ctl_init_done
  );

endinterface

// File: rtl/sdram_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational (zero latency).
// On a tie the client that did not win last time is chosen.
module rr_pick2
  import sdram_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  client_t last_grant,
  output logic    grant_valid,
  output client_t grant_id
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = CLIENT_A;
    if (req_a && req_b) begin
      grant_id = other_client(last_grant);
    end else if (req_b) begin
      grant_id = CLIENT_B;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client round-robin front end for the SDRAM controller; grant-to-ctl_start 1 clk,
// one access in flight, the losing client's start is simply held pending until its turn.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  sdram_arbiter_if.master  bus
);

  state_t            state;
  client_t           grant;
  client_t           last_grant;
  logic              init_lost;
  logic              rel_first;

  logic              ctl_start_r;
  logic              ctl_we_r;
  logic [ADDR_W-1:0] ctl_addr_r;
  logic [DATA_W-1:0] ctl_d_r;
  logic [DATA_W-1:0] a_q_r;
  logic [DATA_W-1:0] b_q_r;
  logic              a_done_r;
  logic              b_done_r;

  logic              pick_vld;
  client_t           pick_id;

  rr_pick2 u_pick (
    .req_a       (bus.a_start),
    .req_b       (bus.b_start),
    .last_grant  (last_grant),
    .grant_valid (pick_vld),
    .grant_id    (pick_id)
  );

  assign bus.ctl_start = ctl_start_r;
  assign bus.ctl_we    = ctl_we_r;
  assign bus.ctl_addr  = ctl_addr_r;
  assign bus.ctl_d     = ctl_d_r;
  assign bus.a_q       = a_q_r;
  assign bus.b_q       = b_q_r;
  assign bus.a_done    = a_done_r;
  assign bus.b_done    = b_done_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_WAIT_INIT;
      grant       <= CLIENT_A;
      last_grant  <= CLIENT_B;
      init_lost   <= 1'b0;
      rel_first   <= 1'b0;
      ctl_start_r <= 1'b0;
      ctl_we_r    <= 1'b0;
      ctl_addr_r  <= '0;
      ctl_d_r     <= '0;
      a_q_r       <= '0;
      b_q_r       <= '0;
      a_done_r    <= 1'b0;
      b_done_r    <= 1'b0;
    end else begin
      a_done_r <= 1'b0;
      b_done_r <= 1'b0;

      case (state)
        S_WAIT_INIT: begin
          if (bus.ctl_init_done) begin
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (!bus.ctl_init_done) begin
            state <= S_WAIT_INIT;
          end else if (!bus.ctl_busy && pick_vld) begin
            grant       <= pick_id;
            last_grant  <= pick_id;
            init_lost   <= 1'b0;
            ctl_start_r <= 1'b1;
            if (pick_id == CLIENT_A) begin
              ctl_we_r   <= bus.a_we;
              ctl_addr_r <= bus.a_addr;
              ctl_d_r    <= bus.a_d;
            end else begin
              ctl_we_r   <= bus.b_we;
              ctl_addr_r <= bus.b_addr;
              ctl_d_r    <= bus.b_d;
            end
            state <= S_ISSUE;
          end
        end

        // Refresh may stretch this state arbitrarily; there is no timeout by design.
        S_ISSUE: begin
          if (!bus.ctl_init_done) begin
            init_lost <= 1'b1;
          end
          if (bus.ctl_q_ready) begin
            if (grant == CLIENT_A) begin
              a_done_r <= 1'b1;
              if (!ctl_we_r) a_q_r <= bus.ctl_q;
            end else begin
              b_done_r <= 1'b1;
              if (!ctl_we_r) b_q_r <= bus.ctl_q;
            end
            ctl_start_r <= 1'b0;
            rel_first   <= 1'b1;
            state       <= S_RELEASE;
          end
        end

        // The forced first cycle gives the finished client time to drop a stale start.
        S_RELEASE: begin
          rel_first <= 1'b0;
          if (!bus.ctl_init_done) begin
            init_lost <= 1'b1;
          end
          if (!rel_first && !bus.ctl_busy && !bus.ctl_q_ready) begin
            state <= (init_lost || !bus.ctl_init_done) ? S_WAIT_INIT : S_IDLE;
          end
        end

        default: state <= S_WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a reactive controller model and protocol monitors.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sdram_arbiter_if bus ();

  sdram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: busy from start, optional refresh delay, q_ready held until start falls.
  logic [31:0] mem [logic [23:0]];
  logic [23:0] log_q [$];
  int          mdl_delay = 0;
  int          mdl_cnt   = 0;
  int          mdl_phase = 0;
  logic        mdl_we;
  logic [23:0] mdl_addr;
  logic [31:0] mdl_d;

  initial begin
    bus.ctl_busy    = 1'b0;
    bus.ctl_q_ready = 1'b0;
    bus.ctl_q       = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mdl_phase       = 0;
        bus.ctl_busy    = 1'b0;
        bus.ctl_q_ready = 1'b0;
        bus.ctl_q       = '0;
      end else begin
        case (mdl_phase)
          0: if (bus.ctl_start) begin
            bus.ctl_busy = 1'b1;
            mdl_cnt   = mdl_delay;
            mdl_we    = bus.ctl_we;
            mdl_addr  = bus.ctl_addr;
            mdl_d     = bus.ctl_d;
            log_q.push_back(bus.ctl_addr);
            mdl_phase = 1;
          end
          1: if (mdl_cnt > 0) begin
            mdl_cnt--;
          end else begin
            if (mdl_we) mem[mdl_addr] = mdl_d;
            else bus.ctl_q = mem.exists(mdl_addr) ? mem[mdl_addr] : {8'hC3, mdl_addr};
            bus.ctl_q_ready = 1'b1;
            mdl_phase = 2;
          end
          default: if (!bus.ctl_start) begin
            bus.ctl_q_ready = 1'b0;
            bus.ctl_busy    = 1'b0;
            mdl_phase       = 0;
          end
        endcase
      end
    end
  end

  // Monitors: done pulses, field stability while start is high, done-to-grant spacing.
  int   a_done_cnt = 0, b_done_cnt = 0;
  int   v_overlap = 0, v_stable = 0, v_spacing = 0;
  int   since_done = 100;
  logic prev_start = 1'b0, prev_a = 1'b0, prev_b = 1'b0;
  logic [56:0] snap = '0;

  always @(posedge clk) begin
    #1;
    if (bus.a_done) a_done_cnt++;
    if (bus.b_done) b_done_cnt++;
    if (bus.a_done && bus.b_done) v_overlap++;
    if ((bus.a_done && prev_a) || (bus.b_done && prev_b)) v_overlap++;
    if (bus.ctl_start && !prev_start) begin
      if (since_done < 2) v_spacing++;
      snap = {bus.ctl_we, bus.ctl_addr, bus.ctl_d};
    end else if (bus.ctl_start && ({bus.ctl_we, bus.ctl_addr, bus.ctl_d} != snap)) begin
      v_stable++;
    end
    if (bus.a_done || bus.b_done) since_done = 0;
    else if (since_done < 100) since_done++;
    prev_start = bus.ctl_start;
    prev_a     = bus.a_done;
    prev_b     = bus.b_done;
  end

  typedef struct {
    client_t     cl;
    logic        we;
    logic [23:0] addr;
    logic [31:0] d;
    int          delay;
    logic [31:0] exp_q;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int          a0, b0, ea, eb;
    logic        got;
    logic [31:0] q;
    mdl_delay = v.delay;
    a0 = a_done_cnt;
    b0 = b_done_cnt;
    if (v.cl == CLIENT_A) begin
      bus.a_we = v.we; bus.a_addr = v.addr; bus.a_d = v.d; bus.a_start = 1'b1;
    end else begin
      bus.b_we = v.we; bus.b_addr = v.addr; bus.b_d = v.d; bus.b_start = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ctl_start) begin got = 1'b1; break; end
    end
    check($sformatf("%s fields", tag), {got, bus.ctl_we, bus.ctl_addr, bus.ctl_d},
          {1'b1, v.we, v.addr, v.d});
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if ((v.cl == CLIENT_A) ? bus.a_done : bus.b_done) begin got = 1'b1; break; end
    end
    q = (v.cl == CLIENT_A) ? bus.a_q : bus.b_q;
    if (v.cl == CLIENT_A) bus.a_start = 1'b0;
    else bus.b_start = 1'b0;
    check($sformatf("%s done_q", tag), {got, q}, {1'b1, v.exp_q});
    repeat (4) @(posedge clk);
    #1;
    ea = (v.cl == CLIENT_A) ? 1 : 0;
    eb = 1 - ea;
    check($sformatf("%s done_count", tag), {a_done_cnt - a0, b_done_cnt - b0}, {ea, eb});
  endtask

  int timeouts = 0;

  task automatic client_loop(input client_t c, input logic [23:0] base);
    logic got;
    for (int i = 0; i < 4; i++) begin
      if (c == CLIENT_A) begin
        bus.a_we = 1'b0; bus.a_addr = base + 24'(i); bus.a_start = 1'b1;
      end else begin
        bus.b_we = 1'b0; bus.b_addr = base + 24'(i); bus.b_start = 1'b1;
      end
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if ((c == CLIENT_A) ? bus.a_done : bus.b_done) begin got = 1'b1; break; end
      end
      if (!got) timeouts++;
    end
    if (c == CLIENT_A) bus.a_start = 1'b0;
    else bus.b_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [8];
  vec_t rec;

  initial begin
    int          hits, a_base;
    logic        got;
    logic [23:0] act_addr, exp_addr;

    vecs[0] = '{CLIENT_A, 1'b0, 24'h000123, 32'h0,        0, 32'hDEADBEEF};
    vecs[1] = '{CLIENT_B, 1'b1, 24'hFFFFFF, 32'h12345678, 0, 32'h00000000};
    vecs[2] = '{CLIENT_B, 1'b0, 24'hFFFFFF, 32'h0,        1, 32'h12345678};
    vecs[3] = '{CLIENT_A, 1'b1, 24'h000123, 32'hCAFEF00D, 0, 32'hDEADBEEF};
    vecs[4] = '{CLIENT_A, 1'b0, 24'h000123, 32'h0,        2, 32'hCAFEF00D};
    vecs[5] = '{CLIENT_B, 1'b1, 24'h000000, 32'hA5A55A5A, 3, 32'h12345678};
    vecs[6] = '{CLIENT_A, 1'b0, 24'h000000, 32'h0,        8, 32'hA5A55A5A};
    vecs[7] = '{CLIENT_B, 1'b0, 24'h000456, 32'h0,        0, 32'hC3000456};
    mem[24'h000123] = 32'hDEADBEEF;

    bus.a_start = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_d = '0;
    bus.b_start = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_d = '0;
    bus.ctl_init_done = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.ctl_start, bus.ctl_we, bus.ctl_addr, bus.ctl_d,
                            bus.a_q, bus.b_q, bus.a_done, bus.b_done}, '0);
    reset = 1'b1;

    // Init gating: request held while the controller is still initialising.
    bus.a_addr = 24'h000321; bus.a_start = 1'b1;
    hits = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.ctl_start) hits++;
    end
    check("init_gating_start_cycles", hits, 0);
    bus.ctl_init_done = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (bus.ctl_start) begin got = 1'b1; break; end
    end
    check("init_release_start_addr", {got, bus.ctl_addr}, {1'b1, 24'h000321});
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.a_done) begin got = 1'b1; break; end
    end
    bus.a_start = 1'b0;
    check("init_read_q", {got, bus.a_q}, {1'b1, 32'hC3000321});
    repeat (4) @(posedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Contention: both clients stream four reads; last grant was B, so A leads.
    log_q.delete();
    mdl_delay = 0;
    fork
      client_loop(CLIENT_A, 24'h000100);
      client_loop(CLIENT_B, 24'h000200);
    join
    check("contention_timeouts", timeouts, 0);
    check("contention_grant_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_addr = ((i % 2) == 0) ? 24'h000100 + 24'(i / 2) : 24'h000200 + 24'(i / 2);
      act_addr = (i < log_q.size()) ? log_q[i] : 24'hxxxxxx;
      check($sformatf("contention_order%0d", i), act_addr, exp_addr);
    end
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a long access.
    mdl_delay = 20;
    a_base = a_done_cnt;
    bus.a_we = 1'b0; bus.a_addr = 24'h000010; bus.a_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ctl_start) break;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.ctl_init_done = 1'b0;
    #1;
    check("reset_midop_outputs", {bus.ctl_start, bus.ctl_we, bus.ctl_addr, bus.ctl_d,
                                  bus.a_q, bus.b_q, bus.a_done, bus.b_done}, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    hits = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.ctl_start) hits++;
    end
    check("reset_wait_init_start_cycles", hits, 0);
    bus.a_start = 1'b0;
    bus.ctl_init_done = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_no_done_for_aborted", a_done_cnt - a_base, 0);

    rec = '{CLIENT_B, 1'b0, 24'h000456, 32'h0, 0, 32'hC3000456};
    run_vec(rec, "recover");

    check("mon_done_overlap_or_long", v_overlap, 0);
    check("mon_fields_stable", v_stable, 0);
    check("mon_done_to_grant_spacing", v_spacing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-client front end placed directly upstream of the SDRAM controller; drives its start/we/addr/d handshake and consumes busy, q_ready, q and initDone.
- Port A serves the CPU memory unit; port B serves the DMA/GPU fetch path.
- Grants one access at a time with round-robin fairness, latches each request and returns read data with a one-cycle done pulse per client.

Parameters:
- ADDR_W, 24, word address width; matches the controller addr.
- DATA_W, 32, data width; matches the controller d and q.

Ports:
- clk  in  1  system clock; same clock as the SDRAM controller.
- reset  in  1  asynchronous, active-low reset.
- a_start  in  1  client A request; held high until a_done.
- a_we  in  1  client A write (1) or read (0).
- a_addr  in  ADDR_W  client A word address.
- a_d  in  DATA_W  client A write data.
- a_q  out  DATA_W  client A read data; valid with a_done and held until A's next done.
- a_done  out  1  one-cycle completion pulse for client A.
- b_start, b_we, b_addr, b_d, b_q, b_done: same as the A signals, for client B.
- ctl_start  out  1  to controller start.
- ctl_we  out  1  to controller we.
- ctl_addr  out  ADDR_W  to controller addr.
- ctl_d  out  DATA_W  to controller d.
- ctl_busy  in  1  from controller busy.
- ctl_q  in  DATA_W  from controller q.
- ctl_q_ready  in  1  from controller q_ready; asserted for reads and writes, held high until ctl_start falls.
- ctl_init_done  in  1  from controller initDone.

Behaviour:
- Reset values (asynchronous on reset low): all outputs 0, state S_WAIT_INIT, last_grant = B, so A wins the first tie.
- All outputs are registered.
- S_WAIT_INIT: ignore clients; go to S_IDLE when ctl_init_done = 1.
- S_IDLE: act only if ctl_busy = 0 and at least one x_start = 1.
  - Single requester: grant it.
  - Both requesting: grant the client that is not last_grant.
  - On grant: latch we/addr/d into ctl_we/ctl_addr/ctl_d, set ctl_start = 1, record grant and last_grant, go to S_ISSUE.
  - Grant-to-ctl_start latency: 1 clk.
- S_ISSUE:
  - Hold ctl_start and the latched fields stable. Client inputs may change without effect.
  - Controller refresh may delay the access; keep waiting and do not count or abort.
  - On the first cycle with ctl_q_ready = 1:
    - On a read, capture ctl_q into the granted client's x_q. On a write, x_q is unchanged.
    - Pulse x_done for 1 clk.
    - Drop ctl_start, go to S_RELEASE.
- S_RELEASE:
  - ctl_start = 0.
  - Go to S_IDLE when ctl_busy = 0 and ctl_q_ready = 0.
  - This ensures the controller has returned to idle before the next grant.
- Client rule: deassert x_start on the cycle after x_done, or present a new request.
  - S_RELEASE lasts at least 2 clk, so a stale start is never re-granted.
  - A new request from the same client is legal and competes normally under round-robin.
- Simultaneous events:
  - A done pulse and a new grant never occur in the same cycle.
  - The non-granted client's start is simply held pending; it starves for at most one access.
- ctl_init_done falling in any state: finish the current access, then return to S_WAIT_INIT instead of S_IDLE.
- Reset mid-access: ctl_start drops immediately and the in-flight request is lost with no done pulse. The controller is reset by the same reset source.

Decomposition:
- Shared package sdram_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the state enum {S_WAIT_INIT, S_IDLE, S_ISSUE, S_RELEASE};
  - the client id type (CLIENT_A = 0, CLIENT_B = 1).
- The arbitration choice is a natural sub-module, rr_pick2: pure combinational, inputs req_a, req_b, last_grant; outputs grant_valid, grant_id.
- Everything else stays flat in sdram_arbiter.

Test Plan:
- Init gating: hold ctl_init_done = 0 for 50 clk with a_start = 1 -> ctl_start stays 0; raise init_done -> ctl_start = 1 within 2 clk with ctl_addr = a_addr.
- Single read: a_start, a_we = 0, a_addr = 0x000123; controller model returns 0xDEADBEEF -> a_done pulses 1 clk, a_q = 0xDEADBEEF, b_done stays 0.
- Single write: b_we = 1, b_addr = 0xFFFFFF, b_d = 0x12345678 -> ctl_d = 0x12345678, ctl_we = 1 throughout S_ISSUE; b_done pulses; b_q unchanged.
- Contention: a_start and b_start asserted together for 4 back-to-back requests each -> grants alternate A, B, A, B...; no done pulse within 2 clk of a grant.
- Refresh overlap: controller model holds busy for 8 clk without q_ready after ctl_start rises -> ctl_start held, fields stable, a single done pulse afterward.
- Reset mid-op: assert reset during S_ISSUE -> all outputs 0 asynchronously; after release, S_WAIT_INIT is re-entered and no done pulse occurs for the aborted request.
